wb_select_pipe: RTL

//   Registered write-back stage for the pipelined MIPS datapath. Per instruction it:
//   - selects one of NSRC result sources (ALU, DM, PC+4, ext, ...);
//   - resolves the destination register: rt, rd or the link register;
//   - buffers the result in a 2-entry skid buffer with valid/ready handshakes on both sides.

---
 rtl/wb_select_pipe.sv | 123 ++++++++++++
 1 files changed

// File: rtl/wb_select_pipe.sv
// Registered MIPS write-back stage: source select, destination resolve, 2-entry skid buffer.
// Define WB_FWD_EN to expose the head-entry forwarding outputs fwd_valid/fwd_addr/fwd_data.
module wb_select_pipe #(
  parameter int DW       = 32,
  parameter int NSRC     = 4,
  parameter int SELW     = 2,
  parameter int AW       = 5,
  parameter int LINK_REG = 31
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SELW-1:0]    in_sel,
  input  logic [NSRC*DW-1:0] in_data,
  input  logic [1:0]         in_dst_sel,
  input  logic [AW-1:0]      in_rt,
  input  logic [AW-1:0]      in_rd,
  input  logic               in_we,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_we,
  output logic [AW-1:0]      out_addr,
  output logic [DW-1:0]      out_data,
  output logic               sel_err
`ifdef WB_FWD_EN
  ,
  output logic               fwd_valid,
  output logic [AW-1:0]      fwd_addr,
  output logic [DW-1:0]      fwd_data
`endif
);

  typedef struct packed {
    logic          v;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  entry_t        head_q, head_d, skid_q, skid_d, new_e;
  logic          sel_err_q, sel_err_d;
  logic          sel_ok, dst_nowr, accept, pop;
  logic [DW-1:0] mux_data;
  logic [AW-1:0] dst_addr;

  assign sel_ok = (32'(in_sel) < 32'(NSRC));
  assign accept = in_valid && in_ready;
  assign pop    = head_q.v && out_ready;

  always_comb begin
    mux_data = '0;
    for (int unsigned k = 0; k < NSRC; k++) begin
      if (32'(in_sel) == k) mux_data = in_data[k*DW +: DW];
    end
  end

  always_comb begin
    dst_addr = '0;
    dst_nowr = 1'b0;
    case (in_dst_sel)
      2'b00:   dst_addr = in_rt;
      2'b01:   dst_addr = in_rd;
      2'b10:   dst_addr = AW'(LINK_REG);
      default: dst_nowr = 1'b1;
    endcase
  end

  always_comb begin
    new_e      = '0;
    new_e.v    = 1'b1;
    new_e.addr = dst_addr;
    new_e.we   = in_we && sel_ok && !dst_nowr && (dst_addr != '0);
    new_e.data = sel_ok ? mux_data : '0;
  end

  // Skid only fills while the head is stalled; in_ready=!skid.v keeps it from overflowing.
  always_comb begin
    head_d    = head_q;
    skid_d    = skid_q;
    sel_err_d = sel_err_q || (accept && !sel_ok);
    if (!head_q.v) begin
      if (accept) head_d = new_e;
    end else if (pop) begin
      if (skid_q.v) begin
        head_d = skid_q;
        skid_d = '0;
      end else if (accept) begin
        head_d = new_e;
      end else begin
        head_d = '0;
      end
    end else if (accept) begin
      skid_d = new_e;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q    <= '0;
      skid_q    <= '0;
      sel_err_q <= 1'b0;
    end else begin
      head_q    <= head_d;
      skid_q    <= skid_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign in_ready  = !skid_q.v;
  assign out_valid = head_q.v;
  assign out_we    = head_q.we;
  assign out_addr  = head_q.addr;
  assign out_data  = head_q.data;
  assign sel_err   = sel_err_q;

`ifdef WB_FWD_EN
  assign fwd_valid = head_q.v && head_q.we;
  assign fwd_addr  = head_q.addr;
  assign fwd_data  = head_q.data;
`endif

endmodule
